// File: rtl/decode_control_sequencer.sv
// decode_control_sequencer
//
// Upstream stage of the decode unit's one-word control register. Instruction
// words arrive over a valid/ready handshake. Each accepted opcode is decoded
// into one registered control word (AR, BR, ALU, input, wren) plus the
// instruction's immediate field. The block also sequences the two-cycle store,
// emits bubbles while downstream stalls, parks in HALT after a halt
// instruction, and counts retired instructions.
//
// Ports
//   CLK         in   1      clock, rising edge
//   RST_N       in   1      asynchronous active-low reset
//   INST_IN     in   IW     instruction word: opcode in the top 4 bits, immediate below
//   INST_VALID  in   1      INST_IN carries a valid instruction
//   INST_READY  out  1      sequencer takes INST_IN this cycle (combinational)
//   STALL       in   1      downstream cannot take a control word; emit a bubble
//   AR_OUT      out  1      load AR
//   BR_OUT      out  1      load BR
//   ALU_OUT     out  1      select ALU result
//   input_OUT   out  1      select external input
//   wren_OUT    out  1      memory write enable (second cycle of a store only)
//   IMM_OUT     out  IW-4   immediate of the instruction behind the current word
//   ILLEGAL     out  1      one-cycle pulse when an undefined opcode is accepted
//   HALTED      out  1      high while parked in HALT
//   RETIRED     out  CW     retired-instruction count, wraps silently
module decode_control_sequencer #(
  parameter int IW = 8,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [IW-1:0] INST_IN,
  input  logic          INST_VALID,
  output logic          INST_READY,
  input  logic          STALL,
  output logic          AR_OUT,
  output logic          BR_OUT,
  output logic          ALU_OUT,
  output logic          input_OUT,
  output logic          wren_OUT,
  output logic [IW-5:0] IMM_OUT,
  output logic          ILLEGAL,
  output logic          HALTED,
  output logic [CW-1:0] RETIRED
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_ST2  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_IN  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit order: {AR, BR, ALU, input, wren}
  localparam logic [4:0] CW_NONE = 5'b00000;
  localparam logic [4:0] CW_LDA  = 5'b10000;
  localparam logic [4:0] CW_LDB  = 5'b01000;
  localparam logic [4:0] CW_ADD  = 5'b10100;
  localparam logic [4:0] CW_IN   = 5'b10010;
  localparam logic [4:0] CW_ST   = 5'b01000;
  localparam logic [4:0] CW_WREN = 5'b00001;

  logic [1:0]    state_q, state_d;
  logic [4:0]    ctrl_q, ctrl_d;
  logic [IW-5:0] imm_q, imm_d;
  logic          illegal_q, illegal_d;
  logic [CW-1:0] retired_q, retired_d;
  logic          retire;
  logic          accept;
  logic [3:0]    opcode;

  assign opcode = INST_IN[IW-1:IW-4];

  // Ready is gated by RST_N so that nothing looks acceptable while reset is
  // held, even though the state register already sits at RUN.
  assign INST_READY = RST_N & (state_q == S_RUN) & ~STALL;
  assign accept     = INST_VALID & INST_READY;

  // Next-state and next-word decode. Control bits default to a bubble every
  // cycle; the immediate defaults to holding, so it survives bubbles and the
  // whole ST2 phase. Stores retire on their wren cycle, not on acceptance.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = CW_NONE;
    imm_d     = imm_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          imm_d  = INST_IN[IW-5:0];
          retire = (opcode != OP_ST);
          case (opcode)
            OP_NOP: ctrl_d = CW_NONE;
            OP_LDA: ctrl_d = CW_LDA;
            OP_LDB: ctrl_d = CW_LDB;
            OP_ADD: ctrl_d = CW_ADD;
            OP_IN:  ctrl_d = CW_IN;
            OP_ST: begin
              ctrl_d  = CW_ST;
              state_d = S_ST2;
            end
            OP_HLT: state_d = S_HALT;
            default: illegal_d = 1'b1;
          endcase
        end
      end
      S_ST2: begin
        if (!STALL) begin
          ctrl_d  = CW_WREN;
          retire  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
    retired_d = retired_q + {{(CW-1){1'b0}}, retire};
  end

  // All architectural state; reset abandons any store in flight and clears
  // the retired count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_RUN;
      ctrl_q    <= CW_NONE;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign AR_OUT    = ctrl_q[4];
  assign BR_OUT    = ctrl_q[3];
  assign ALU_OUT   = ctrl_q[2];
  assign input_OUT = ctrl_q[1];
  assign wren_OUT  = ctrl_q[0];
  assign IMM_OUT   = imm_q;
  assign ILLEGAL   = illegal_q;
  assign HALTED    = (state_q == S_HALT);
  assign RETIRED   = retired_q;

endmodule

// File: tb/tb_decode_control_sequencer.sv
// tb_decode_control_sequencer
//
// Directed bench for decode_control_sequencer, built with CW=4 so the retired
// counter wrap is reachable quickly. Inputs change on the falling edge; the
// ready flag is sampled just after the inputs settle, and registered outputs
// are sampled on the following falling edge.
module tb_decode_control_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] INST_IN = 8'h00;
  logic       INST_VALID = 1'b0;
  logic       INST_READY;
  logic       STALL = 1'b0;
  logic       AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT;
  logic [3:0] IMM_OUT;
  logic       ILLEGAL;
  logic       HALTED;
  logic [3:0] RETIRED;

  int   total = 0;
  int   bad = 0;
  logic readySeen;
  logic [14:0] obs;

  decode_control_sequencer #(
    .IW(8),
    .CW(4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .INST_IN   (INST_IN),
    .INST_VALID(INST_VALID),
    .INST_READY(INST_READY),
    .STALL     (STALL),
    .AR_OUT    (AR_OUT),
    .BR_OUT    (BR_OUT),
    .ALU_OUT   (ALU_OUT),
    .input_OUT (input_OUT),
    .wren_OUT  (wren_OUT),
    .IMM_OUT   (IMM_OUT),
    .ILLEGAL   (ILLEGAL),
    .HALTED    (HALTED),
    .RETIRED   (RETIRED)
  );

  always #5 CLK = ~CLK;

  // Observed output bundle: {AR,BR,ALU,input,wren, IMM, ILLEGAL, HALTED, RETIRED}
  assign obs = {AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT, IMM_OUT, ILLEGAL, HALTED, RETIRED};

  // Packs hand-computed expectations into the same layout as obs.
  function automatic logic [14:0] w(input logic [4:0] c, input logic [3:0] imm,
                                    input logic ill, input logic h, input logic [3:0] r);
    return {c, imm, ill, h, r};
  endfunction

  // Drive one cycle from a falling edge: apply inputs, sample ready, advance to
  // the next falling edge so the registered outputs reflect the rising edge.
  task automatic step(input logic v, input logic [7:0] inst, input logic s);
    INST_VALID = v;
    INST_IN    = inst;
    STALL      = s;
    #1 readySeen = INST_READY;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    @(negedge CLK);
    INST_VALID = 1'b1;
    INST_IN    = 8'h13;
    STALL      = 1'b0;
    RST_N      = 1'b0;
    #1;
    total++;
    if (obs !== w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0)) begin
      bad++; $display("[TB] FAIL reset_outputs got=%h want=%h", obs, w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0));
    end
    total++;
    if (INST_READY !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ready got=%b want=0", INST_READY);
    end
    @(negedge CLK);
    total++;
    if (obs !== w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0)) begin
      bad++; $display("[TB] FAIL reset_held got=%h want=%h", obs, w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0));
    end
    RST_N = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [7:0]  insts [3];
    logic [14:0] exps [3];
    insts = '{8'h13, 8'h37, 8'h4A};
    exps  = '{w(5'b10000, 4'h3, 1'b0, 1'b0, 4'd1),
              w(5'b10100, 4'h7, 1'b0, 1'b0, 4'd2),
              w(5'b10010, 4'hA, 1'b0, 1'b0, 4'd3)};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, insts[i], 1'b0);
      total++;
      if (readySeen !== 1'b1) begin
        bad++; $display("[TB] FAIL b2b_ready[%0d] got=%b want=1", i, readySeen);
      end
      total++;
      if (obs !== exps[i]) begin
        bad++; $display("[TB] FAIL b2b_word[%0d] got=%h want=%h", i, obs, exps[i]);
      end
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if (obs !== w(5'b00000, 4'hA, 1'b0, 1'b0, 4'd3)) begin
      bad++; $display("[TB] FAIL b2b_bubble got=%h want=%h", obs, w(5'b00000, 4'hA, 1'b0, 1'b0, 4'd3));
    end
  endtask

  task automatic test_store;
    step(1'b1, 8'h55, 1'b0);
    total++;
    if (obs !== w(5'b01000, 4'h5, 1'b0, 1'b0, 4'd3)) begin
      bad++; $display("[TB] FAIL st_first got=%h want=%h", obs, w(5'b01000, 4'h5, 1'b0, 1'b0, 4'd3));
    end
    // A valid LDA offered during ST2 must not be taken.
    step(1'b1, 8'h13, 1'b0);
    total++;
    if (readySeen !== 1'b0) begin
      bad++; $display("[TB] FAIL st2_ready got=%b want=0", readySeen);
    end
    total++;
    if (obs !== w(5'b00001, 4'h5, 1'b0, 1'b0, 4'd4)) begin
      bad++; $display("[TB] FAIL st_wren got=%h want=%h", obs, w(5'b00001, 4'h5, 1'b0, 1'b0, 4'd4));
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if ({readySeen, obs} !== {1'b1, w(5'b00000, 4'h5, 1'b0, 1'b0, 4'd4)}) begin
      bad++; $display("[TB] FAIL st_after got=%b/%h want=1/%h", readySeen, obs, w(5'b00000, 4'h5, 1'b0, 1'b0, 4'd4));
    end
  endtask

  task automatic test_store_stall;
    step(1'b1, 8'h52, 1'b0);
    total++;
    if (obs !== w(5'b01000, 4'h2, 1'b0, 1'b0, 4'd4)) begin
      bad++; $display("[TB] FAIL sts_first got=%h want=%h", obs, w(5'b01000, 4'h2, 1'b0, 1'b0, 4'd4));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++;
      if ({readySeen, obs} !== {1'b0, w(5'b00000, 4'h2, 1'b0, 1'b0, 4'd4)}) begin
        bad++; $display("[TB] FAIL sts_bubble[%0d] got=%b/%h want=0/%h", i, readySeen, obs, w(5'b00000, 4'h2, 1'b0, 1'b0, 4'd4));
      end
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if (obs !== w(5'b00001, 4'h2, 1'b0, 1'b0, 4'd5)) begin
      bad++; $display("[TB] FAIL sts_wren got=%h want=%h", obs, w(5'b00001, 4'h2, 1'b0, 1'b0, 4'd5));
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if ({readySeen, obs} !== {1'b1, w(5'b00000, 4'h2, 1'b0, 1'b0, 4'd5)}) begin
      bad++; $display("[TB] FAIL sts_no_double got=%b/%h want=1/%h", readySeen, obs, w(5'b00000, 4'h2, 1'b0, 1'b0, 4'd5));
    end
  endtask

  task automatic test_run_stall;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h21, 1'b1);
      total++;
      if ({readySeen, obs} !== {1'b0, w(5'b00000, 4'h2, 1'b0, 1'b0, 4'd5)}) begin
        bad++; $display("[TB] FAIL run_stall[%0d] got=%b/%h want=0/%h", i, readySeen, obs, w(5'b00000, 4'h2, 1'b0, 1'b0, 4'd5));
      end
    end
    step(1'b1, 8'h21, 1'b0);
    total++;
    if ({readySeen, obs} !== {1'b1, w(5'b01000, 4'h1, 1'b0, 1'b0, 4'd6)}) begin
      bad++; $display("[TB] FAIL run_release got=%b/%h want=1/%h", readySeen, obs, w(5'b01000, 4'h1, 1'b0, 1'b0, 4'd6));
    end
  endtask

  task automatic test_illegal_halt;
    step(1'b1, 8'h96, 1'b0);
    total++;
    if (obs !== w(5'b00000, 4'h6, 1'b1, 1'b0, 4'd7)) begin
      bad++; $display("[TB] FAIL illegal_word got=%h want=%h", obs, w(5'b00000, 4'h6, 1'b1, 1'b0, 4'd7));
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if (obs !== w(5'b00000, 4'h6, 1'b0, 1'b0, 4'd7)) begin
      bad++; $display("[TB] FAIL illegal_pulse got=%h want=%h", obs, w(5'b00000, 4'h6, 1'b0, 1'b0, 4'd7));
    end
    step(1'b1, 8'hF0, 1'b0);
    total++;
    if (obs !== w(5'b00000, 4'h0, 1'b0, 1'b1, 4'd8)) begin
      bad++; $display("[TB] FAIL halt_enter got=%h want=%h", obs, w(5'b00000, 4'h0, 1'b0, 1'b1, 4'd8));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h13, 1'b0);
      total++;
      if ({readySeen, obs} !== {1'b0, w(5'b00000, 4'h0, 1'b0, 1'b1, 4'd8)}) begin
        bad++; $display("[TB] FAIL halt_hold[%0d] got=%b/%h want=0/%h", i, readySeen, obs, w(5'b00000, 4'h0, 1'b0, 1'b1, 4'd8));
      end
    end
    RST_N = 1'b0;
    #1;
    total++;
    if (obs !== w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0)) begin
      bad++; $display("[TB] FAIL halt_reset got=%h want=%h", obs, w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0));
    end
    @(negedge CLK);
    RST_N = 1'b1;
    step(1'b1, 8'h13, 1'b0);
    total++;
    if ({readySeen, obs} !== {1'b1, w(5'b10000, 4'h3, 1'b0, 1'b0, 4'd1)}) begin
      bad++; $display("[TB] FAIL halt_rerun got=%b/%h want=1/%h", readySeen, obs, w(5'b10000, 4'h3, 1'b0, 1'b0, 4'd1));
    end
  endtask

  task automatic test_wrap_and_reset;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 15; i++) step(1'b1, 8'h00, 1'b0);
    total++;
    if (obs !== w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd15)) begin
      bad++; $display("[TB] FAIL wrap_top got=%h want=%h", obs, w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd15));
    end
    step(1'b1, 8'h00, 1'b0);
    total++;
    if (obs !== w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0)) begin
      bad++; $display("[TB] FAIL wrap_zero got=%h want=%h", obs, w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0));
    end
    step(1'b1, 8'h5C, 1'b0);
    total++;
    if (obs !== w(5'b01000, 4'hC, 1'b0, 1'b0, 4'd0)) begin
      bad++; $display("[TB] FAIL mid_st_first got=%h want=%h", obs, w(5'b01000, 4'hC, 1'b0, 1'b0, 4'd0));
    end
    // Reset lands mid-cycle while in ST2, before the wren edge.
    INST_VALID = 1'b0;
    STALL      = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    total++;
    if ({INST_READY, obs} !== {1'b0, w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0)}) begin
      bad++; $display("[TB] FAIL mid_st_reset got=%b/%h want=0/%h", INST_READY, obs, w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0));
    end
    @(negedge CLK);
    RST_N = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    total++;
    if ({readySeen, obs} !== {1'b1, w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0)}) begin
      bad++; $display("[TB] FAIL mid_st_no_wren got=%b/%h want=1/%h", readySeen, obs, w(5'b00000, 4'h0, 1'b0, 1'b0, 4'd0));
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_store;
    test_store_stall;
    test_run_stall;
    test_illegal_halt;
    test_wrap_and_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
